// File: rtl/p66b_blocklock_if.sv
// Word stream between blocks: gearbox -> block lock -> descrambler.
interface p66b_blocklock_if;
  logic        valid;
  logic        ready;
  logic [65:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/p66b_blocklock.sv
// 64b/66b receive block-lock: hunts sync headers, requests gearbox bit slips,
// and forwards only words seen while locked through a single output register.
module p66b_blocklock #(
  parameter int LOCK_COUNT = 64,
  parameter int WINDOW     = 1024,
  parameter int BAD_LIMIT  = 16,
  parameter int SLIP_WAIT  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  p66b_blocklock_if.slave   i_rx,
  p66b_blocklock_if.master  o_tx,
  output logic              o_slip,
  output logic              o_locked,
  output logic              o_overflow
);

  localparam int GC_W = $clog2(LOCK_COUNT) + 1;
  localparam int WC_W = $clog2(WINDOW) + 1;
  localparam int BC_W = $clog2(BAD_LIMIT) + 1;
  localparam int SW_W = $clog2(SLIP_WAIT) + 1;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOCKED = 2'd1,
    SLIP   = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [GC_W-1:0]   r_good_cnt, w_good_nxt;
  logic [WC_W-1:0]   r_win_cnt, w_win_nxt;
  logic [BC_W-1:0]   r_bad_cnt, w_bad_nxt;
  logic [SW_W-1:0]   r_wait_cnt, w_wait_nxt;
  logic              r_slip, w_slip_nxt;
  logic              r_locked, w_locked_nxt;
  logic              r_overflow, w_overflow_nxt;
  logic              r_tx_valid, w_tx_valid_nxt;
  logic [65:0]       r_tx_data, w_tx_data_nxt;

  logic              w_hdr_ok;
  logic              w_fwd;
  logic [GC_W-1:0]   w_good_inc;
  logic [WC_W-1:0]   w_win_inc;
  logic [BC_W-1:0]   w_bad_inc;
  logic [SW_W-1:0]   w_wait_inc;

  // The gearbox cannot be stalled, so the input side always accepts.
  assign i_rx.ready = 1'b1;

  assign w_hdr_ok   = i_rx.data[0] ^ i_rx.data[1];
  assign w_fwd      = i_rx.valid && (r_state == LOCKED);
  assign w_good_inc = r_good_cnt + GC_W'(1);
  assign w_win_inc  = r_win_cnt + WC_W'(1);
  assign w_bad_inc  = r_bad_cnt + BC_W'(!w_hdr_ok);
  assign w_wait_inc = r_wait_cnt + SW_W'(1);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_bad_cnt  <= '0;
      r_wait_cnt <= '0;
      r_slip     <= 1'b0;
      r_locked   <= 1'b0;
      r_overflow <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_win_cnt  <= w_win_nxt;
      r_bad_cnt  <= w_bad_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_slip     <= w_slip_nxt;
      r_locked   <= w_locked_nxt;
      r_overflow <= w_overflow_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_win_nxt    = r_win_cnt;
    w_bad_nxt    = r_bad_cnt;
    w_wait_nxt   = r_wait_cnt;
    w_slip_nxt   = 1'b0;
    w_locked_nxt = r_locked;

    if (i_rx.valid) begin
      case (r_state)
        HUNT: begin
          // A bad header beats a lock-completing count on the same word.
          if (!w_hdr_ok) begin
            w_slip_nxt  = 1'b1;
            w_good_nxt  = '0;
            w_wait_nxt  = '0;
            w_state_nxt = SLIP;
          end else if (w_good_inc == GC_W'(LOCK_COUNT)) begin
            w_locked_nxt = 1'b1;
            w_good_nxt   = '0;
            w_win_nxt    = '0;
            w_bad_nxt    = '0;
            w_state_nxt  = LOCKED;
          end else begin
            w_good_nxt = w_good_inc;
          end
        end
        LOCKED: begin
          // Loss of lock takes priority over the window-end clear.
          if (w_bad_inc == BC_W'(BAD_LIMIT)) begin
            w_locked_nxt = 1'b0;
            w_slip_nxt   = 1'b1;
            w_good_nxt   = '0;
            w_win_nxt    = '0;
            w_bad_nxt    = '0;
            w_wait_nxt   = '0;
            w_state_nxt  = SLIP;
          end else if (w_win_inc == WC_W'(WINDOW)) begin
            w_win_nxt = '0;
            w_bad_nxt = '0;
          end else begin
            w_win_nxt = w_win_inc;
            w_bad_nxt = w_bad_inc;
          end
        end
        SLIP: begin
          if (w_wait_inc == SW_W'(SLIP_WAIT)) begin
            w_wait_nxt  = '0;
            w_good_nxt  = '0;
            w_state_nxt = HUNT;
          end else begin
            w_wait_nxt = w_wait_inc;
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_good_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_overflow_nxt = 1'b0;
    if (w_fwd) begin
      if (!r_tx_valid || o_tx.ready) begin
        w_tx_valid_nxt = 1'b1;
        w_tx_data_nxt  = i_rx.data;
      end else begin
        w_overflow_nxt = 1'b1;
      end
    end else if (o_tx.ready) begin
      w_tx_valid_nxt = 1'b0;
    end
  end

  assign o_tx.valid = r_tx_valid;
  assign o_tx.data  = r_tx_data;
  assign o_slip     = r_slip;
  assign o_locked   = r_locked;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_p66b_blocklock.sv
// Directed bench for p66b_blocklock: lock, slip, loss, window clear, stall, reset.
module tb_p66b_blocklock;
  logic i_clk = 1'b0;
  logic i_reset_n;
  logic o_slip, o_locked, o_overflow;

  p66b_blocklock_if rx_if ();
  p66b_blocklock_if tx_if ();

  p66b_blocklock dut (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_rx       (rx_if.slave),
    .o_tx       (tx_if.master),
    .o_slip     (o_slip),
    .o_locked   (o_locked),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  int          checks = 0;
  int          errors = 0;
  int          slip_cnt = 0;
  int          ovf_cnt = 0;
  int          unlock_cnt = 0;
  logic [63:0] seq = 64'h1000;
  logic [65:0] last_word;
  logic [65:0] first_word;

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    slip_cnt += int'(o_slip);
    ovf_cnt  += int'(o_overflow);
    if (!o_locked) unlock_cnt++;
  endtask

  task automatic word(input logic [1:0] hdr);
    rx_if.valid = 1'b1;
    rx_if.data  = {seq, hdr};
    last_word   = {seq, hdr};
    seq++;
    @(posedge i_clk); #1;
    rx_if.valid = 1'b0;
    observe();
  endtask

  task automatic idle();
    rx_if.valid = 1'b0;
    @(posedge i_clk); #1;
    observe();
  endtask

  task automatic good_words(input int n);
    for (int k = 0; k < n; k++) word(2'b01);
  endtask

  initial begin
    i_reset_n   = 1'b0;
    rx_if.valid = 1'b0;
    rx_if.data  = '0;
    tx_if.ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_locked", 66'(o_locked), 66'(0));
    chk("rst_slip", 66'(o_slip), 66'(0));
    chk("rst_valid", 66'(tx_if.valid), 66'(0));
    chk("rst_data", tx_if.data, 66'(0));
    chk("rst_ovf", 66'(o_overflow), 66'(0));
    i_reset_n = 1'b1;
    idle();

    // lock acquisition
    slip_cnt = 0;
    good_words(63);
    chk("lock_63_not_locked", 66'(o_locked), 66'(0));
    word(2'b10);
    chk("lock_64_locked", 66'(o_locked), 66'(1));
    chk("lock_no_slip", 66'(slip_cnt), 66'(0));
    chk("lock_word64_not_fwd", 66'(tx_if.valid), 66'(0));
    word(2'b01);
    chk("lock_word65_valid", 66'(tx_if.valid), 66'(1));
    chk("lock_word65_data", tx_if.data, last_word);

    // loss of lock: 16 bad headers interleaved among good words
    for (int b = 1; b <= 16; b++) begin
      good_words(6);
      word(2'b11);
      if (b == 15) chk("loss_15_still_locked", 66'(o_locked), 66'(1));
    end
    chk("loss_locked_low", 66'(o_locked), 66'(0));
    chk("loss_slip", 66'(o_slip), 66'(1));
    chk("loss_word_fwd_valid", 66'(tx_if.valid), 66'(1));
    chk("loss_word_fwd_data", tx_if.data, last_word);
    word(2'b01);
    chk("loss_slip_one_cycle", 66'(o_slip), 66'(0));
    chk("loss_next_not_fwd", 66'(tx_if.valid), 66'(0));
    good_words(3);

    // hunt slip, ignored settle words, then 63 vs 64 good
    slip_cnt = 0;
    good_words(10);
    word(2'b11);
    chk("hunt_slip", 66'(o_slip), 66'(1));
    for (int k = 0; k < 4; k++) word(2'b00);
    chk("hunt_settle_ignored", 66'(slip_cnt), 66'(1));
    good_words(63);
    chk("hunt_63_not_locked", 66'(o_locked), 66'(0));
    word(2'b01);
    chk("hunt_64_locked", 66'(o_locked), 66'(1));

    // three windows of 15 bad headers, one on each window's final word
    slip_cnt = 0;
    unlock_cnt = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 1024; i++) begin
        if ((i < 14) || (i == 1023)) word(2'b00);
        else                         word(2'b01);
      end
    end
    chk("win_never_unlocked", 66'(unlock_cnt), 66'(0));
    chk("win_no_slip", 66'(slip_cnt), 66'(0));
    chk("win_locked_end", 66'(o_locked), 66'(1));

    // 16th bad header lands on the final word of a window
    for (int i = 0; i < 1023; i++) begin
      if (i < 15) word(2'b11);
      else        word(2'b01);
    end
    chk("winend_pre_locked", 66'(o_locked), 66'(1));
    word(2'b11);
    chk("winend_loss", 66'(o_locked), 66'(0));
    chk("winend_slip", 66'(o_slip), 66'(1));

    good_words(4);
    good_words(64);
    chk("relock", 66'(o_locked), 66'(1));

    // stall / overflow
    ovf_cnt = 0;
    tx_if.ready = 1'b0;
    word(2'b01);
    first_word = last_word;
    chk("stall_first_valid", 66'(tx_if.valid), 66'(1));
    chk("stall_first_no_ovf", 66'(o_overflow), 66'(0));
    word(2'b01);
    chk("stall_ovf_pulse", 66'(o_overflow), 66'(1));
    word(2'b10);
    chk("stall_hold_data", tx_if.data, first_word);
    chk("stall_ovf_count", 66'(ovf_cnt), 66'(2));
    tx_if.ready = 1'b1;
    idle();
    chk("stall_valid_drop", 66'(tx_if.valid), 66'(0));
    chk("stall_ovf_clear", 66'(o_overflow), 66'(0));
    idle();
    chk("idle_hold_locked", 66'(o_locked), 66'(1));

    // reset mid-lock
    word(2'b01);
    chk("prerst_valid", 66'(tx_if.valid), 66'(1));
    i_reset_n = 1'b0;
    idle();
    chk("midrst_locked", 66'(o_locked), 66'(0));
    chk("midrst_valid", 66'(tx_if.valid), 66'(0));
    i_reset_n = 1'b1;
    good_words(63);
    chk("rehunt_63", 66'(o_locked), 66'(0));
    word(2'b01);
    chk("rehunt_64", 66'(o_locked), 66'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/p66b_blocklock.md
# p66b_blocklock

Receive-side 64b/66b block-lock controller for the 10GBASE-R path, placed between the RX gearbox and the RX descrambler. It monitors the 2-bit sync header of every 66-bit word and issues one-cycle bit-slip requests to the gearbox until alignment is found. It declares lock after a run of good headers and drops lock when too many bad headers appear within a window. Only words received while locked are forwarded to the descrambler.

## Interface

- LOCK_COUNT, 64: consecutive valid headers needed to declare lock (2..1023)
- WINDOW, 1024: locked-state monitoring window, in valid words (power of two, ≥ 2*BAD_LIMIT)
- BAD_LIMIT, 16: bad headers within one window that force loss of lock (≥ 1)
- SLIP_WAIT, 4: valid words ignored after a slip, so the gearbox settles (≥ 1)
- i_clk  in  1  clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_valid  in  1  word from the gearbox; the source cannot be stalled
- i_data  in  66  word; sync header in [1:0], bit 0 first on the wire
- o_slip  out  1  one-cycle pulse: gearbox shifts alignment by one bit
- o_locked  out  1  block lock status
- o_valid  out  1  word available to the descrambler
- i_ready  in  1  descrambler ready
- o_data  out  66  forwarded word, unmodified
- o_overflow  out  1  one-cycle pulse: forwarded word dropped because of a stall

## Operation

- Valid header: i_data[1:0] == 2'b01 or 2'b10. Invalid header: 2'b00 or 2'b11. Only words with i_valid=1 are evaluated.
- States: HUNT, LOCKED, SLIP.
- **HUNT:**
  - A valid header increments good_cnt.
  - When good_cnt reaches LOCK_COUNT, go to LOCKED with o_locked=1 and clear the counters.
  - An invalid header pulses o_slip, clears good_cnt and goes to SLIP.
- **LOCKED:**
  - Each valid word increments win_cnt; each invalid header also increments bad_cnt.
  - If this word brings bad_cnt to BAD_LIMIT:
    - o_locked=0 and o_slip pulse;
    - go to SLIP and clear all counters.
  - Else if win_cnt reaches WINDOW, clear win_cnt and bad_cnt.
    - The word that completes the window still counts toward bad_cnt before the clear.
- **SLIP:**
  - wait_cnt counts valid words regardless of header.
  - After SLIP_WAIT words, go to HUNT with good_cnt=0.
  - Headers are not evaluated in SLIP.
- **Forwarding:** a valid word is forwarded iff the state is LOCKED when it is presented. This includes the word that causes loss of lock; the 64th word that achieves lock is not forwarded.
- **Output register:**
  - Forwarded word with o_valid=0 or i_ready=1: load o_data and set o_valid=1.
  - Forwarded word with o_valid=1 and i_ready=0: drop the new word, hold the old one, pulse o_overflow.
  - No forwarded word and i_ready=1: clear o_valid.
- **Counter widths:** $clog2 of each limit plus 1. No counter wraps; each is cleared on a state change or at the window end.

## Timing

- **Reset:**
  - State HUNT, all counters 0.
  - o_slip=0, o_locked=0, o_valid=0, o_data=0, o_overflow=0.
  - A reset mid-operation abandons lock immediately and also clears o_valid.
- All outputs are registered.
  - o_slip, o_locked and o_overflow change on the clock edge that samples the triggering word.
  - Forwarding latency is 1 cycle from i_valid to o_valid.
- o_slip is high for exactly one cycle per slip event. Minimum spacing is SLIP_WAIT+1 valid words.
- An invalid header on the same word that would complete LOCK_COUNT: the slip wins and lock is not declared.
- A bad header that hits BAD_LIMIT on the final word of a window: lock is lost, and the window clear does not apply.
- i_valid=0 cycles advance nothing, and state is held.

## Test plan

- **Lock acquisition:** reset, then 64 words with header 2'b01. o_locked rises on the edge sampling word 64, with no o_slip. Word 65 appears on o_data one cycle later.
- **Hunt slip:** 10 good words, then header 2'b11. o_slip is one cycle high, and the next 4 valid words are ignored. Then 64 good words produce o_locked=1; 63 good words do not.
- **Loss of lock:** locked, then 16 bad headers interleaved among 100 good words. o_locked falls and o_slip pulses on the 16th bad header. That word is forwarded; the next one is not.
- **Window clear:** locked, with 15 bad headers in each of three consecutive 1024-word windows. o_locked stays 1 throughout, and o_slip never pulses.
- **Stall/overflow:** locked, i_ready=0 for 3 valid words. o_data holds the first word, and o_overflow pulses twice. With i_ready=1, o_valid drops the cycle after the stall ends if no new words arrive.
- **Reset mid-lock:** assert i_reset_n=0 for one cycle while locked with o_valid=1. The next cycle shows o_locked=0 and o_valid=0, and the block re-hunts from good_cnt=0.
